vdma_irq_responder: RTL and testbench
=====================================

# vdma_irq_responder

Hardware interrupt responder for the VDMA interrupt controller. It watches the controller's `interrupt_o` and `status_reg_o` lines, picks pending sources in round-robin order, and hands each event to a downstream consumer over a valid/ready handshake. After each handshake it issues exactly one single-cycle clear pulse on the controller's `interrupt_clear_i`. Each pulse retires one counted occurrence, so queued occurrences of the same source are serviced one by one, with no software involvement.

## Interface
Parameters:
- NUM_SRC, 5: number of interrupt sources. Bit index = source ID.
- SETTLE_CYCLES, 3: wait cycles after a clear pulse before status is re-sampled. Legal range 1..15.
- CNT_W, 16: width of each per-source serviced-event counter.

Ports:
- sys_clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  responder enable
- interrupt_i  in  1  aggregate interrupt from the controller
- status_reg_i  in  NUM_SRC  per-source status from the controller
- interrupt_overflow_i  in  NUM_SRC  per-source overflow flags from the controller
- src_mask_i  in  NUM_SRC  1 = source serviced; 0 = ignored
- interrupt_clear_o  out  NUM_SRC  one-hot clear pulse to the controller
- evt_valid_o  out  1  event offered to the consumer
- evt_src_o  out  3  source ID of the offered event
- evt_ready_i  in  1  consumer accepts the event
- evt_count_o  out  NUM_SRC*CNT_W  serviced-event counters; source i occupies bits [i*CNT_W +: CNT_W]
- busy_o  out  1  FSM is not in IDLE
- overflow_seen_o  out  1  sticky OR of all interrupt_overflow_i bits

## Operation
- pend = status_reg_i & src_mask_i.
- FSM states: IDLE, ARB, NOTIFY, CLEAR, SETTLE.
- IDLE:
  - If enable_i && interrupt_i && pend != 0, go to ARB.
  - If interrupt_i is high but pend == 0, stay in IDLE and issue no clear.
- ARB:
  - Round-robin pick from pend, searching from last_src+1 upward with wrap at NUM_SRC-1 -> 0.
  - Latch the winner into cur_src and last_src, then go to NOTIFY.
  - If pend has dropped to 0, return to IDLE.
- NOTIFY:
  - evt_valid_o = 1; evt_src_o = cur_src.
  - Both are held stable until evt_ready_i is sampled high; valid is never withdrawn before the handshake.
  - On the handshake cycle, go to CLEAR.
- CLEAR:
  - interrupt_clear_o[cur_src] = 1 for exactly one cycle.
  - Counter cur_src increments and saturates at all-ones.
  - Load settle_cnt = SETTLE_CYCLES, then go to SETTLE.
- SETTLE:
  - Decrement settle_cnt.
  - When it reaches 0: go to ARB if enable_i && pend != 0, otherwise go to IDLE.
  - A source still pending (more queued occurrences) is re-serviced, subject to round-robin order.
- enable_i low mid-operation: the current event completes (NOTIFY -> CLEAR -> SETTLE), then the FSM goes to IDLE.
- Mask changes take effect only at the next ARB. An in-flight event is not cancelled.
- overflow_seen_o sets on any interrupt_overflow_i bit and is cleared only by reset.
- Reset mid-operation: all state returns to reset values immediately and no clear pulse is emitted.

## Timing
- Reset values:
  - FSM = IDLE; interrupt_clear_o = 0; evt_valid_o = 0; evt_src_o = 0.
  - evt_count_o = 0; busy_o = 0; overflow_seen_o = 0.
  - last_src = NUM_SRC-1, so the first arbitration favours source 0.
- All outputs are registered.
- Latency:
  - interrupt_i / pend sampled high in IDLE -> evt_valid_o high 2 cycles later.
  - Handshake cycle -> interrupt_clear_o pulse on the next cycle.
  - Counter value updates the cycle after the pulse.
- Minimum per-event period with evt_ready_i tied high: 1 (ARB) + 1 (NOTIFY) + 1 (CLEAR) + SETTLE_CYCLES = 6 cycles at defaults.
- SETTLE_CYCLES ≥ 3 is required at the default design point. It covers the controller's one-cycle counter and status update after a clear.

## Configuration
- VDMA_IRQ_RESP_STATS_EN defined: per-source saturating counters are built and drive evt_count_o.
- Not defined: no counter registers are built; evt_count_o is tied to 0. All other behaviour is identical.

## Structure
- Package vdma_irq_pkg contains:
  - the state enum;
  - the source-ID constants: 0 frame_end, 1 buff_addr_fifo_full, 2 buff_addr_fifo_empty, 3 frame_size_fifo_full, 4 frame_size_fifo_empty;
  - default NUM_SRC.
- One sub-module: vdma_rr_arbiter.
  - Inputs: request vector, last-grant index.
  - Outputs: grant index, any-grant flag.
  - Purely combinational.

## Test plan
- Single event: status=5'b00001, interrupt_i=1, ready=1 -> evt_src_o=0 two cycles later, one clear pulse 5'b00001, count[0]=1, then IDLE.
- Queued repeats: source 3 held pending for 3 occurrences -> three handshakes and three clear pulses 5'b01000, count[3]=3; status drop after the third clear -> IDLE.
- Round-robin: status=5'b10110 held -> service order 1, 2, 4, 1, ...; source 0 masked off via src_mask_i=5'b11110 is never serviced.
- Backpressure: ready held low for 10 cycles -> valid and src stable for those cycles, no clear pulse; ready high -> clear pulse on the next cycle.
- Reset mid-NOTIFY: rstn_i low while valid=1 -> all outputs 0 immediately, no clear pulse; after release, the FSM restarts from IDLE.
- Overflow/saturation: interrupt_overflow_i[2] pulses -> overflow_seen_o=1 and stays 1. With CNT_W=4, 17 events -> count stays at 4'hF.

Source files
------------

// File: rtl/vdma_irq_pkg.sv
// Shared constants for the VDMA interrupt responder: FSM state encoding,
// interrupt source IDs and the default source count.
package vdma_irq_pkg;

    localparam int unsigned NUM_SRC_DEF = 5;
    localparam int unsigned SRC_ID_W    = 3;
    localparam int unsigned STATE_W     = 3;
    localparam int unsigned SETTLE_W    = 4;

    // FSM state encoding
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_ARB    = 3'd1;
    localparam logic [STATE_W-1:0] ST_NOTIFY = 3'd2;
    localparam logic [STATE_W-1:0] ST_CLEAR  = 3'd3;
    localparam logic [STATE_W-1:0] ST_SETTLE = 3'd4;

    // Interrupt source IDs (bit index into status / clear vectors)
    localparam logic [SRC_ID_W-1:0] SRC_FRAME_END            = 3'd0;
    localparam logic [SRC_ID_W-1:0] SRC_BUFF_ADDR_FIFO_FULL  = 3'd1;
    localparam logic [SRC_ID_W-1:0] SRC_BUFF_ADDR_FIFO_EMPTY = 3'd2;
    localparam logic [SRC_ID_W-1:0] SRC_FRAME_SIZE_FIFO_FULL = 3'd3;
    localparam logic [SRC_ID_W-1:0] SRC_FRAME_SIZE_FIFO_EMPTY= 3'd4;

endpackage

// File: rtl/vdma_rr_arbiter.sv
// Combinational round-robin picker: first requester after i_last, wrapping
// from NUM_SRC-1 back to 0.
module vdma_rr_arbiter
    import vdma_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = NUM_SRC_DEF,
    parameter int unsigned IDX_W   = 3
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_gnt,
    output logic               o_any
);

    int w_idx;

    // Scan from farthest to nearest so the nearest requester wins
    always_comb begin
        o_gnt = '0;
        o_any = 1'b0;
        w_idx = 0;
        for (int k = int'(NUM_SRC); k >= 1; k--) begin
            w_idx = (int'(i_last) + k) % int'(NUM_SRC);
            if (i_req[IDX_W'(w_idx)]) begin
                o_gnt = IDX_W'(w_idx);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vdma_irq_responder.sv
// Hardware interrupt responder: round-robin services pending VDMA interrupt
// sources over a valid/ready handshake, issuing one clear pulse per event.
// Optional per-source serviced-event counters: define VDMA_IRQ_RESP_STATS_EN.
module vdma_irq_responder
    import vdma_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC       = NUM_SRC_DEF,
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                     sys_clk_i,
    input  logic                     rstn_i,
    input  logic                     enable_i,
    input  logic                     interrupt_i,
    input  logic [NUM_SRC-1:0]       status_reg_i,
    input  logic [NUM_SRC-1:0]       interrupt_overflow_i,
    input  logic [NUM_SRC-1:0]       src_mask_i,
    output logic [NUM_SRC-1:0]       interrupt_clear_o,
    output logic                     evt_valid_o,
    output logic [SRC_ID_W-1:0]      evt_src_o,
    input  logic                     evt_ready_i,
    output logic [NUM_SRC*CNT_W-1:0] evt_count_o,
    output logic                     busy_o,
    output logic                     overflow_seen_o
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [STATE_W-1:0]  r_state,      w_state_nxt;
    logic [IDX_W-1:0]    r_cur_src,    w_cur_src_nxt;
    logic [IDX_W-1:0]    r_last_src,   w_last_src_nxt;
    logic [SETTLE_W-1:0] r_settle_cnt, w_settle_nxt;
    logic [NUM_SRC-1:0]  r_clear,      w_clear_nxt;
    logic                r_evt_valid,  w_evt_valid_nxt;
    logic [SRC_ID_W-1:0] r_evt_src,    w_evt_src_nxt;
    logic                r_busy,       w_busy_nxt;
    logic                r_ovf;

    logic [NUM_SRC-1:0]  w_pend;
    logic [IDX_W-1:0]    w_gnt;
    logic                w_any;

    assign w_pend = status_reg_i & src_mask_i;

    vdma_rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req  (w_pend),
        .i_last (r_last_src),
        .o_gnt  (w_gnt),
        .o_any  (w_any)
    );

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_cur_src_nxt  = r_cur_src;
        w_last_src_nxt = r_last_src;
        w_settle_nxt   = r_settle_cnt;
        w_clear_nxt    = '0;
        w_evt_src_nxt  = r_evt_src;

        case (r_state)
            ST_IDLE: begin
                if (enable_i && interrupt_i && (|w_pend)) begin
                    w_state_nxt = ST_ARB;
                end
            end
            ST_ARB: begin
                if (w_any) begin
                    w_cur_src_nxt  = w_gnt;
                    w_last_src_nxt = w_gnt;
                    w_evt_src_nxt  = SRC_ID_W'(w_gnt);
                    w_state_nxt    = ST_NOTIFY;
                end else begin
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_NOTIFY: begin
                if (evt_ready_i) begin
                    w_clear_nxt = NUM_SRC'(1) << r_cur_src;
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_settle_nxt = SETTLE_W'(SETTLE_CYCLES);
                w_state_nxt  = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_settle_nxt = r_settle_cnt - SETTLE_W'(1);
                // Last settle cycle: controller status now reflects the clear
                if (r_settle_cnt <= SETTLE_W'(1)) begin
                    w_state_nxt = (enable_i && (|w_pend)) ? ST_ARB : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_evt_valid_nxt = (w_state_nxt == ST_NOTIFY);
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ST_IDLE;
            r_cur_src    <= '0;
            r_last_src   <= IDX_W'(NUM_SRC - 1);
            r_settle_cnt <= '0;
            r_clear      <= '0;
            r_evt_valid  <= 1'b0;
            r_evt_src    <= '0;
            r_busy       <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_src    <= w_cur_src_nxt;
            r_last_src   <= w_last_src_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_clear      <= w_clear_nxt;
            r_evt_valid  <= w_evt_valid_nxt;
            r_evt_src    <= w_evt_src_nxt;
            r_busy       <= w_busy_nxt;
            r_ovf        <= r_ovf | (|interrupt_overflow_i);
        end
    end

    assign interrupt_clear_o = r_clear;
    assign evt_valid_o       = r_evt_valid;
    assign evt_src_o         = r_evt_src;
    assign busy_o            = r_busy;
    assign overflow_seen_o   = r_ovf;

`ifdef VDMA_IRQ_RESP_STATS_EN
    logic [NUM_SRC*CNT_W-1:0] r_cnt;

    // Saturating per-source count, bumped while the clear pulse is out
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if ((IDX_W'(i) == r_cur_src) && (r_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    r_cnt[i*CNT_W +: CNT_W] <= r_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    assign evt_count_o = r_cnt;
`else
    assign evt_count_o = '0;
`endif

endmodule

// File: tb/tb_vdma_irq_responder.sv
// Scoreboard bench for vdma_irq_responder with a small occurrence-counting
// model of the interrupt controller driving status_reg_i / interrupt_i.
module tb_vdma_irq_responder;

    localparam int unsigned NS = 5;
    localparam int unsigned CW = 4;
`ifdef VDMA_IRQ_RESP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            sys_clk_i;
    logic            rstn_i;
    logic            enable_i;
    logic            interrupt_i;
    logic [NS-1:0]   status_reg_i;
    logic [NS-1:0]   interrupt_overflow_i;
    logic [NS-1:0]   src_mask_i;
    logic [NS-1:0]   interrupt_clear_o;
    logic            evt_valid_o;
    logic [2:0]      evt_src_o;
    logic            evt_ready_i;
    logic [NS*CW-1:0] evt_count_o;
    logic            busy_o;
    logic            overflow_seen_o;

    int   n_checks;
    int   n_errors;
    int   occ [NS];
    logic irq_extra;
    int   exp_q [$];

    vdma_irq_responder #(
        .NUM_SRC       (NS),
        .SETTLE_CYCLES (3),
        .CNT_W         (CW)
    ) dut (
        .sys_clk_i            (sys_clk_i),
        .rstn_i               (rstn_i),
        .enable_i             (enable_i),
        .interrupt_i          (interrupt_i),
        .status_reg_i         (status_reg_i),
        .interrupt_overflow_i (interrupt_overflow_i),
        .src_mask_i           (src_mask_i),
        .interrupt_clear_o    (interrupt_clear_o),
        .evt_valid_o          (evt_valid_o),
        .evt_src_o            (evt_src_o),
        .evt_ready_i          (evt_ready_i),
        .evt_count_o          (evt_count_o),
        .busy_o               (busy_o),
        .overflow_seen_o      (overflow_seen_o)
    );

    initial sys_clk_i = 1'b0;
    always #5 sys_clk_i = ~sys_clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        if (!STATS) return 32'd0;
        return (n > 15) ? 32'd15 : 32'(n);
    endfunction

    function automatic logic [31:0] cnt_of(input int i);
        return 32'(evt_count_o[i*CW +: CW]);
    endfunction

    task automatic apply();
        for (int i = 0; i < int'(NS); i++) status_reg_i[i] = (occ[i] != 0);
        interrupt_i = (|status_reg_i) | irq_extra;
    endtask

    // One clock: the controller retires one occurrence per observed clear pulse
    task automatic tick();
        logic [NS-1:0] c;
        c = interrupt_clear_o;
        @(posedge sys_clk_i);
        #1;
        for (int i = 0; i < int'(NS); i++) if (c[i] && occ[i] > 0) occ[i]--;
        apply();
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!evt_valid_o && k < 50) begin
            tick();
            k++;
        end
        check({name, "_valid_timeout"}, 32'(evt_valid_o), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        tick();
        tick();
        while (busy_o && k < 400) begin
            tick();
            k++;
        end
        check({name, "_idle_timeout"}, 32'(busy_o), 32'd0);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Pops the expected source on each handshake; checks the following clear pulse
    task automatic monitor();
        logic          hs_prev;
        logic [NS-1:0] exp_clr;
        int            e;
        hs_prev = 1'b0;
        exp_clr = '0;
        forever begin
            @(negedge sys_clk_i);
            if (!rstn_i) begin
                hs_prev = 1'b0;
            end else begin
                if (hs_prev || interrupt_clear_o != '0)
                    check("clear_pulse", 32'(interrupt_clear_o), hs_prev ? 32'(exp_clr) : 32'd0);
                hs_prev = 1'b0;
                if (evt_valid_o && evt_ready_i) begin
                    hs_prev = 1'b1;
                    if (exp_q.size() == 0) begin
                        exp_clr = '0;
                        check("unexpected_event", 32'(evt_src_o), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        exp_clr = NS'(1) << e;
                        check("event_src", 32'(evt_src_o), 32'(e));
                    end
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rstn_i = 1'b0;
        enable_i = 1'b1;
        irq_extra = 1'b0;
        evt_ready_i = 1'b1;
        src_mask_i = '1;
        interrupt_overflow_i = '0;
        for (int i = 0; i < int'(NS); i++) occ[i] = 0;
        apply();
        fork
            monitor();
        join_none

        repeat (3) @(posedge sys_clk_i);
        #1;
        check("rst_clear", 32'(interrupt_clear_o), 32'd0);
        check("rst_valid", 32'(evt_valid_o), 32'd0);
        check("rst_src", 32'(evt_src_o), 32'd0);
        check("rst_count", 32'(evt_count_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ovf", 32'(overflow_seen_o), 32'd0);
        rstn_i = 1'b1;
        tick();
        tick();

        // Single event with latency checks
        occ[0] = 1;
        exp_q.push_back(0);
        apply();
        tick();
        check("t1_arb_valid", 32'(evt_valid_o), 32'd0);
        check("t1_arb_busy", 32'(busy_o), 32'd1);
        tick();
        check("t1_notify_valid", 32'(evt_valid_o), 32'd1);
        check("t1_notify_src", 32'(evt_src_o), 32'd0);
        tick();
        check("t1_clear", 32'(interrupt_clear_o), 32'h01);
        check("t1_clear_valid", 32'(evt_valid_o), 32'd0);
        tick();
        check("t1_count0", cnt_of(0), exp_cnt(1));
        wait_idle("t1");

        // Aggregate interrupt with nothing pending
        irq_extra = 1'b1;
        apply();
        repeat (4) tick();
        check("nopend_busy", 32'(busy_o), 32'd0);
        check("nopend_valid", 32'(evt_valid_o), 32'd0);
        irq_extra = 1'b0;
        apply();

        // Pending but masked, then unmasked
        src_mask_i = 5'b11110;
        occ[0] = 1;
        apply();
        repeat (4) tick();
        check("masked_busy", 32'(busy_o), 32'd0);
        exp_q.push_back(0);
        src_mask_i = '1;
        wait_idle("unmask");
        check("unmask_count0", cnt_of(0), exp_cnt(2));

        // Queued repeats of source 3
        occ[3] = 3;
        repeat (3) exp_q.push_back(3);
        apply();
        wait_idle("repeat");
        check("repeat_count3", cnt_of(3), exp_cnt(3));

        // Reset, then round-robin with source 0 masked off
        rstn_i = 1'b0;
        tick();
        check("rst2_count", 32'(evt_count_o), 32'd0);
        rstn_i = 1'b1;
        tick();
        occ[0] = 3; occ[1] = 2; occ[2] = 2; occ[4] = 2;
        src_mask_i = 5'b11110;
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(4);
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(4);
        apply();
        wait_idle("rr");
        check("rr_count1", cnt_of(1), exp_cnt(2));
        check("rr_count2", cnt_of(2), exp_cnt(2));
        check("rr_count4", cnt_of(4), exp_cnt(2));
        check("rr_count0", cnt_of(0), exp_cnt(0));
        repeat (3) tick();
        check("rr_masked_idle", 32'(busy_o), 32'd0);
        occ[0] = 0;
        src_mask_i = '1;
        apply();

        // Backpressure: valid/src hold for 10 cycles, no clear
        evt_ready_i = 1'b0;
        occ[2] = 1;
        exp_q.push_back(2);
        apply();
        wait_valid("bp");
        for (int i = 0; i < 10; i++) begin
            check("bp_valid_hold", 32'(evt_valid_o), 32'd1);
            check("bp_src_hold", 32'(evt_src_o), 32'd2);
            check("bp_no_clear", 32'(interrupt_clear_o), 32'd0);
            tick();
        end
        evt_ready_i = 1'b1;
        tick();
        check("bp_clear", 32'(interrupt_clear_o), 32'h04);
        wait_idle("bp");

        // Enable dropped mid-event: event completes, second occurrence waits
        occ[0] = 2;
        exp_q.push_back(0);
        apply();
        wait_valid("en");
        enable_i = 1'b0;
        wait_idle("en_off");
        repeat (3) tick();
        check("en_off_busy", 32'(busy_o), 32'd0);
        enable_i = 1'b1;
        exp_q.push_back(0);
        wait_idle("en_on");

        // Reset while an event is offered
        evt_ready_i = 1'b0;
        occ[1] = 1;
        apply();
        wait_valid("rstn");
        rstn_i = 1'b0;
        #1;
        check("rstmid_valid", 32'(evt_valid_o), 32'd0);
        check("rstmid_src", 32'(evt_src_o), 32'd0);
        check("rstmid_busy", 32'(busy_o), 32'd0);
        check("rstmid_clear", 32'(interrupt_clear_o), 32'd0);
        tick();
        rstn_i = 1'b1;
        evt_ready_i = 1'b1;
        occ[3] = 1;
        exp_q.push_back(1);
        exp_q.push_back(3);
        apply();
        wait_idle("restart");
        check("restart_count1", cnt_of(1), exp_cnt(1));
        check("restart_count3", cnt_of(3), exp_cnt(1));
        check("restart_count2", cnt_of(2), exp_cnt(0));

        // Sticky overflow flag
        check("ovf_before", 32'(overflow_seen_o), 32'd0);
        interrupt_overflow_i = 5'b00100;
        tick();
        interrupt_overflow_i = '0;
        check("ovf_set", 32'(overflow_seen_o), 32'd1);
        repeat (5) tick();
        check("ovf_sticky", 32'(overflow_seen_o), 32'd1);

        // Counter saturation
        occ[3] = 17;
        repeat (17) exp_q.push_back(3);
        apply();
        wait_idle("sat");
        check("sat_count3", cnt_of(3), exp_cnt(18));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
